// File: rtl/input_port_unit.sv
// NoC router input port: flit FIFO plus XY route computation on head flits,
// presenting one packet at a time to the crossbar with a req/grant handshake.
module input_port_unit #(
    parameter int DEPTH = 4,
    parameter int MY_X  = 0,
    parameter int MY_Y  = 0,
    parameter int DATAW = 15,
    parameter int VCHW  = 1,
    parameter int PORTW = 2
) (
    input  logic           clk,
    input  logic           rst_,
    input  logic [DATAW:0] in_data,
    input  logic           in_valid,
    input  logic [VCHW:0]  in_vch,
    output logic           in_ready,
    output logic           req,
    output logic [PORTW:0] port,
    input  logic           grt,
    output logic [DATAW:0] odata,
    output logic           ovalid,
    output logic [VCHW:0]  ovch,
    output logic           err_drop
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = DATAW + VCHW + 2;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    localparam logic [PORTW:0] P_LOCAL = (PORTW+1)'(0);
    localparam logic [PORTW:0] P_NORTH = (PORTW+1)'(1);
    localparam logic [PORTW:0] P_EAST  = (PORTW+1)'(2);
    localparam logic [PORTW:0] P_SOUTH = (PORTW+1)'(3);
    localparam logic [PORTW:0] P_WEST  = (PORTW+1)'(4);

    typedef enum logic {IDLE, ACTIVE} state_t;

    logic [EW-1:0]    mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      count_q, count_d;
    state_t           state_q;
    logic             req_q;
    logic [PORTW:0]   port_q;

    logic             empty, full, push, pop, pop_act, drop, pkt_end;
    logic [EW-1:0]    head;
    logic [DATAW:0]   head_data;
    logic [VCHW:0]    head_vch;
    logic [1:0]       head_type;

    // X is resolved before Y, so a packet never turns from a Y hop back to X
    function automatic logic [PORTW:0] route(input logic [3:0] dx, input logic [3:0] dy);
        logic [PORTW:0] r;
        if (dx > 4'(MY_X))      r = P_EAST;
        else if (dx < 4'(MY_X)) r = P_WEST;
        else if (dy > 4'(MY_Y)) r = P_NORTH;
        else if (dy < 4'(MY_Y)) r = P_SOUTH;
        else                    r = P_LOCAL;
        return r;
    endfunction

    assign empty     = (count_q == '0);
    assign full      = (count_q == FULL_CNT);
    assign head      = mem_q[rptr_q];
    assign head_data = head[DATAW:0];
    assign head_vch  = head[EW-1:DATAW+1];
    assign head_type = head_data[DATAW:DATAW-1];

    assign in_ready = !rst_ && !full;
    assign push     = in_valid && in_ready;
    assign drop     = !rst_ && (state_q == IDLE) && !empty && head_type[1];
    assign pop_act  = (state_q == ACTIVE) && grt && !empty;
    assign pop      = drop || pop_act;
    // types 00 (single) and 11 (tail) both close the packet
    assign pkt_end  = pop_act && (head_type[1] == head_type[0]);

    assign req      = req_q;
    assign port     = port_q;
    assign ovalid   = req_q && !empty;
    assign odata    = ovalid ? head_data : '0;
    assign ovch     = ovalid ? head_vch : '0;
    assign err_drop = drop;

    always_comb begin
        wptr_d  = push ? wptr_q + AW'(1) : wptr_q;
        rptr_d  = pop ? rptr_q + AW'(1) : rptr_q;
        count_d = count_q;
        if (push && !pop)
            count_d = count_q + (AW+1)'(1);
        else if (pop && !push)
            count_d = count_q - (AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (rst_) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wptr_q] <= {in_vch, in_data};
    end

    always_ff @(posedge clk) begin
        if (rst_) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            port_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!empty && !head_type[1]) begin
                        state_q <= ACTIVE;
                        req_q   <= 1'b1;
                        port_q  <= route(head_data[7:4], head_data[3:0]);
                    end
                end
                ACTIVE: begin
                    if (pkt_end) begin
                        state_q <= IDLE;
                        req_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_input_port_unit.sv
// Bench for input_port_unit: directed packet scenarios plus a randomized
// flit stream checked against a packet-level reference model.
module tb_input_port_unit;
    localparam int MY_X = 1;
    localparam int MY_Y = 1;

    logic        clk = 1'b0;
    logic        rst_;
    logic [15:0] in_data;
    logic        in_valid;
    logic [1:0]  in_vch;
    logic        in_ready;
    logic        req;
    logic [2:0]  port;
    logic        grt;
    logic [15:0] odata;
    logic        ovalid;
    logic [1:0]  ovch;
    logic        err_drop;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        drop;
        logic [15:0] data;
        logic [1:0]  vch;
        logic [2:0]  port;
    } ev_t;

    input_port_unit #(.DEPTH(4), .MY_X(MY_X), .MY_Y(MY_Y),
                      .DATAW(15), .VCHW(1), .PORTW(2)) dut (
        .clk(clk), .rst_(rst_), .in_data(in_data), .in_valid(in_valid),
        .in_vch(in_vch), .in_ready(in_ready), .req(req), .port(port),
        .grt(grt), .odata(odata), .ovalid(ovalid), .ovch(ovch),
        .err_drop(err_drop)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mk(input logic [1:0] t, input logic [5:0] pl,
                                       input logic [3:0] dx, input logic [3:0] dy);
        return {t, pl, dx, dy};
    endfunction

    function automatic logic [2:0] ref_route(input logic [3:0] dx, input logic [3:0] dy);
        int x = int'(dx);
        int y = int'(dy);
        if (x != MY_X) return (x > MY_X) ? 3'd2 : 3'd4;
        if (y != MY_Y) return (y > MY_Y) ? 3'd1 : 3'd3;
        return 3'd0;
    endfunction

    task automatic test_reset();
        rst_ = 1'b1; in_valid = 1'b0; in_data = '0; in_vch = '0; grt = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b0 || req !== 1'b0 || port !== 3'd0 || ovalid !== 1'b0 ||
            odata !== 16'h0 || ovch !== 2'd0 || err_drop !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: in_ready=%b req=%b port=%0d ovalid=%b odata=%h ovch=%0d err_drop=%b, want all 0",
                     in_ready, req, port, ovalid, odata, ovch, err_drop);
        end
        rst_ = 1'b0;
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_release_ready: in_ready=%b want 1", in_ready);
        end
    endtask

    task automatic test_basic();
        logic [15:0] f [3];
        f[0] = mk(2'b01, 6'h11, 4'd2, 4'd1);
        f[1] = mk(2'b10, 6'h12, 4'd0, 4'd0);
        f[2] = mk(2'b11, 6'h13, 4'd0, 4'd0);
        grt = 1'b1; in_valid = 1'b1; in_data = f[0]; in_vch = 2'd1;
        @(negedge clk);
        n_tests++;
        if (req !== 1'b0) begin n_fail++; $display("FAIL basic_route_cycle: req=%b want 0", req); end
        in_data = f[1];
        @(negedge clk);
        n_tests++;
        if (req !== 1'b1 || port !== 3'd2 || ovalid !== 1'b1 || odata !== f[0]) begin
            n_fail++;
            $display("FAIL basic_head: req=%b port=%0d ovalid=%b odata=%h want 1/2/1/%h", req, port, ovalid, odata, f[0]);
        end
        in_data = f[2];
        @(negedge clk);
        n_tests++;
        if (odata !== f[1] || req !== 1'b1) begin
            n_fail++; $display("FAIL basic_body: odata=%h req=%b want %h/1", odata, req, f[1]);
        end
        in_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (odata !== f[2] || ovalid !== 1'b1 || port !== 3'd2) begin
            n_fail++; $display("FAIL basic_tail: odata=%h ovalid=%b port=%0d want %h/1/2", odata, ovalid, port, f[2]);
        end
        @(negedge clk);
        n_tests++;
        if (req !== 1'b0 || ovalid !== 1'b0) begin
            n_fail++; $display("FAIL basic_release: req=%b ovalid=%b want 0/0", req, ovalid);
        end
        grt = 1'b0;
    endtask

    task automatic test_single();
        logic [15:0] f;
        int nv = 0;
        f = mk(2'b00, 6'h21, 4'd1, 4'd1);
        in_valid = 1'b1; in_data = f; in_vch = 2'd2; grt = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (ovalid) begin
                nv++;
                n_tests++;
                if (odata !== f || port !== 3'd0 || ovch !== 2'd2) begin
                    n_fail++; $display("FAIL single_flit: odata=%h port=%0d ovch=%0d want %h/0/2", odata, port, ovch, f);
                end
            end
        end
        n_tests++;
        if (nv != 1 || req !== 1'b0) begin
            n_fail++; $display("FAIL single_count: ovalid_cycles=%0d req=%b want 1/0", nv, req);
        end
        grt = 1'b0;
    endtask

    task automatic test_full();
        logic [15:0] fl [5];
        int idx = 0;
        int pops = 0;
        fl[0] = mk(2'b01, 6'h31, 4'd1, 4'd2);
        fl[1] = mk(2'b10, 6'h32, 4'd0, 4'd0);
        fl[2] = mk(2'b10, 6'h33, 4'd0, 4'd0);
        fl[3] = mk(2'b11, 6'h34, 4'd0, 4'd0);
        fl[4] = mk(2'b00, 6'h35, 4'd3, 4'd0);
        grt = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (c == 4 || c == 6) begin
                n_tests++;
                if (in_ready !== 1'b0 || idx != 4) begin
                    n_fail++; $display("FAIL full_ready_low: c=%0d in_ready=%b accepted=%0d want 0/4", c, in_ready, idx);
                end
            end
            if (c == 8) begin
                n_tests++;
                if (in_ready !== 1'b1) begin
                    n_fail++; $display("FAIL full_ready_after_pop: in_ready=%b want 1", in_ready);
                end
            end
            if (c >= 7) grt = 1'b1;
            if (ovalid && grt) begin
                n_tests++;
                if (pops >= 5 || odata !== fl[pops]) begin
                    n_fail++; $display("FAIL full_order: pop %0d odata=%h want %h", pops, odata, fl[pops % 5]);
                end
                pops++;
            end
            if (idx < 5) begin
                in_valid = 1'b1; in_data = fl[idx]; in_vch = 2'(idx);
                if (in_ready) idx++;
            end else begin
                in_valid = 1'b0;
            end
        end
        n_tests++;
        if (pops != 5 || idx != 5) begin
            n_fail++; $display("FAIL full_totals: pops=%0d pushes=%0d want 5/5", pops, idx);
        end
        grt = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_drop();
        int nd = 0;
        int nv = 0;
        in_valid = 1'b1; in_data = mk(2'b10, 6'h3f, 4'd2, 4'd2); in_vch = 2'd3; grt = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (err_drop) nd++;
            if (ovalid) nv++;
        end
        n_tests++;
        if (nd != 1 || nv != 0 || req !== 1'b0) begin
            n_fail++; $display("FAIL drop_body: err_drop_cycles=%0d ovalid_cycles=%0d req=%b want 1/0/0", nd, nv, req);
        end
        grt = 1'b0;
    endtask

    task automatic test_stall();
        logic [15:0] fl [4];
        logic [1:0]  vc [4];
        int sched [4] = '{0, 1, 4, 9};
        int idx = 0;
        int pops = 0;
        logic started = 1'b0;
        logic done = 1'b0;
        fl[0] = mk(2'b01, 6'h01, 4'd1, 4'd0); vc[0] = 2'd2;
        fl[1] = mk(2'b10, 6'h02, 4'd0, 4'd0); vc[1] = 2'd1;
        fl[2] = mk(2'b10, 6'h03, 4'd0, 4'd0); vc[2] = 2'd3;
        fl[3] = mk(2'b11, 6'h04, 4'd0, 4'd0); vc[3] = 2'd0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            grt = (c % 2 == 0);
            if (req) started = 1'b1;
            if (started && !done) begin
                n_tests++;
                if (req !== 1'b1 || port !== 3'd3) begin
                    n_fail++; $display("FAIL stall_hold: c=%0d req=%b port=%0d want 1/3", c, req, port);
                end
                if (!ovalid) begin
                    n_tests++;
                    if (odata !== 16'h0 || ovch !== 2'd0) begin
                        n_fail++; $display("FAIL stall_gap_zero: odata=%h ovch=%0d want 0/0", odata, ovch);
                    end
                end
            end
            if (ovalid && grt) begin
                n_tests++;
                if (pops >= 4 || odata !== fl[pops] || ovch !== vc[pops]) begin
                    n_fail++; $display("FAIL stall_order: pop %0d odata=%h ovch=%0d want %h/%0d",
                                       pops, odata, ovch, fl[pops % 4], vc[pops % 4]);
                end
                pops++;
                if (pops == 4) done = 1'b1;
            end
            if (idx < 4 && c >= sched[idx]) begin
                in_valid = 1'b1; in_data = fl[idx]; in_vch = vc[idx];
                if (in_ready) idx++;
            end else begin
                in_valid = 1'b0;
            end
        end
        n_tests++;
        if (pops != 4 || req !== 1'b0) begin
            n_fail++; $display("FAIL stall_totals: pops=%0d req=%b want 4/0", pops, req);
        end
        grt = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [15:0] f;
        int pops = 0;
        grt = 1'b0;
        in_valid = 1'b1; in_data = mk(2'b01, 6'h0a, 4'd2, 4'd1); in_vch = 2'd1;
        @(negedge clk);
        in_data = mk(2'b10, 6'h0b, 4'd0, 4'd0);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (req !== 1'b1 || ovalid !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_active: req=%b ovalid=%b want 1/1", req, ovalid);
        end
        rst_ = 1'b1;
        @(negedge clk);
        n_tests++;
        if (req !== 1'b0 || ovalid !== 1'b0 || in_ready !== 1'b0 || port !== 3'd0) begin
            n_fail++; $display("FAIL rstmid_flush: req=%b ovalid=%b in_ready=%b port=%0d want 0/0/0/0", req, ovalid, in_ready, port);
        end
        rst_ = 1'b0;
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b1 || ovalid !== 1'b0 || err_drop !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_empty: in_ready=%b ovalid=%b err_drop=%b want 1/0/0", in_ready, ovalid, err_drop);
        end
        f = mk(2'b00, 6'h0c, 4'd0, 4'd3);
        in_valid = 1'b1; in_data = f; in_vch = 2'd3; grt = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (ovalid) begin
                n_tests++;
                if (port !== 3'd4 || odata !== f || ovch !== 2'd3) begin
                    n_fail++; $display("FAIL rstmid_new_pkt: port=%0d odata=%h ovch=%0d want 4/%h/3", port, odata, ovch, f);
                end
                pops++;
            end
        end
        n_tests++;
        if (pops != 1) begin
            n_fail++; $display("FAIL rstmid_pops: ovalid_cycles=%0d want 1", pops);
        end
        grt = 1'b0;
    endtask

    task automatic test_random();
        ev_t         eq [$];
        ev_t         e;
        logic        have = 1'b0;
        logic [15:0] cur = '0;
        logic [1:0]  cur_v = '0;
        logic        in_pkt = 1'b0;
        logic [2:0]  cur_port = '0;
        logic [1:0]  t;
        int          sel;
        localparam int NCYC = 1500;
        for (int c = 0; c < NCYC; c++) begin
            @(negedge clk);
            grt = ($urandom_range(0, 9) < 6);
            if (err_drop) begin
                n_tests++;
                if (eq.size() == 0 || !eq[0].drop) begin
                    n_fail++; $display("FAIL rand_drop: c=%0d err_drop=1 but next expected flit is not a drop", c);
                end else begin
                    void'(eq.pop_front());
                end
            end
            if (ovalid && grt) begin
                n_tests++;
                if (eq.size() == 0 || eq[0].drop || req !== 1'b1 ||
                    odata !== eq[0].data || ovch !== eq[0].vch || port !== eq[0].port) begin
                    n_fail++;
                    $display("FAIL rand_pop: c=%0d odata=%h ovch=%0d port=%0d req=%b want %h/%0d/%0d/1 (queue %0d)",
                             c, odata, ovch, port, req,
                             (eq.size() > 0) ? eq[0].data : 16'h0,
                             (eq.size() > 0) ? eq[0].vch : 2'd0,
                             (eq.size() > 0) ? eq[0].port : 3'd0, eq.size());
                end
                if (eq.size() > 0) void'(eq.pop_front());
            end else if (!ovalid && (odata !== 16'h0 || ovch !== 2'd0)) begin
                n_tests++;
                n_fail++; $display("FAIL rand_idle_zero: c=%0d odata=%h ovch=%0d want 0/0", c, odata, ovch);
            end
            if (!have && c < NCYC - 100 && $urandom_range(0, 9) < 7) begin
                sel = $urandom_range(0, 9);
                t = (sel < 3) ? 2'b00 : (sel < 5) ? 2'b01 : (sel < 8) ? 2'b10 : 2'b11;
                cur = mk(t, 6'($urandom), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)));
                cur_v = 2'($urandom);
                have = 1'b1;
            end
            in_valid = have; in_data = cur; in_vch = cur_v;
            if (have && in_ready) begin
                t = cur[15:14];
                e.data = cur; e.vch = cur_v; e.drop = 1'b0; e.port = cur_port;
                if (in_pkt) begin
                    if (t == 2'b00 || t == 2'b11) in_pkt = 1'b0;
                end else if (!t[1]) begin
                    cur_port = ref_route(cur[7:4], cur[3:0]);
                    e.port = cur_port;
                    in_pkt = (t == 2'b01);
                end else begin
                    e.drop = 1'b1;
                end
                eq.push_back(e);
                have = 1'b0;
            end
        end
        n_tests++;
        if (eq.size() != 0) begin
            n_fail++; $display("FAIL rand_drain: %0d expected flits never left the port", eq.size());
        end
        in_valid = 1'b0; grt = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_single();
        test_full();
        test_drop();
        test_stall();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
